// File: rtl/sy_ppl_fetch_lbuf.sv
// L0 fetch line buffer: one-line store in front of the fetch stage,
// 1-cycle hit, line refill over a request/beat-response memory port.
module sy_ppl_fetch_lbuf #(
  parameter int AWTH       = 64,
  parameter int LINE_BYTES = 16,
  parameter int MWTH       = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            fet_req_i,
  input  logic [AWTH-1:0] fet_vaddr_i,
  input  logic            fet_kill_i,
  output logic            fet_ready_o,
  output logic            fet_valid_o,
  output logic [31:0]     fet_data_o,
  output logic            fet_ex_valid_o,
  output logic [AWTH-1:0] fet_ex_tval_o,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [AWTH-1:0] mem_req_addr_o,
  input  logic            mem_rsp_valid_i,
  input  logic [MWTH-1:0] mem_rsp_data_i,
  input  logic            mem_rsp_err_i,
  input  logic            mem_rsp_last_i
);

  localparam int BEATS = LINE_BYTES * 8 / MWTH;
  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int WN    = LINE_BYTES / 4;
  localparam int WPB   = MWTH / 32;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW    = AWTH - OFF;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    ERR
  } st_t;

  st_t                  r_st;
  st_t                  w_nx;
  logic [WN-1:0][31:0]  r_line;
  logic [TW-1:0]        r_tag;
  logic                 r_lv;
  logic [AWTH-1:0]      r_req_addr;
  logic                 r_pend;
  logic                 r_killed;
  logic                 r_kbf;
  logic                 r_err_seen;
  logic [CW-1:0]        r_cnt;

  logic                 w_kill;
  logic                 w_hit;
  logic                 w_hit_rsp;
  logic                 w_refill;
  logic                 w_accept;
  logic                 w_hshk;
  logic                 w_beat;
  logic                 w_last;
  logic                 w_err_any;
  logic                 w_killed_now;
  logic                 w_kbf_now;
  logic [31:0]          w_word;

  assign w_kill       = fet_kill_i | flush_i;
  assign w_hit        = r_lv && (r_tag == r_req_addr[AWTH-1:OFF]);
  assign w_hit_rsp    = (r_st == IDLE) && r_pend && w_hit;
  assign w_refill     = (r_st == MISS_REQ) || (r_st == MISS_WAIT);
  assign w_hshk       = (r_st == MISS_REQ) && mem_req_ready_i;
  assign w_beat       = (r_st == MISS_WAIT) && mem_rsp_valid_i;
  assign w_last       = w_beat && mem_rsp_last_i;
  assign w_err_any    = r_err_seen | mem_rsp_err_i;
  assign w_killed_now = r_killed | w_kill;
  assign w_kbf_now    = r_kbf | flush_i;
  assign w_word       = r_line[r_req_addr[OFF-1:2]];

  assign fet_ready_o  = (r_st == IDLE) && !(r_pend && !w_hit);
  assign w_accept     = fet_req_i && fet_ready_o && !w_kill;

  assign fet_valid_o     = !w_kill && (w_hit_rsp || (r_st == ERR));
  assign fet_data_o      = (!w_kill && w_hit_rsp) ? w_word : 32'h0;
  assign fet_ex_valid_o  = !w_kill && (r_st == ERR);
  assign fet_ex_tval_o   = fet_ex_valid_o ? r_req_addr : '0;
  assign mem_req_valid_o = (r_st == MISS_REQ);
  assign mem_req_addr_o  = mem_req_valid_o ?
                           {r_req_addr[AWTH-1:OFF], {OFF{1'b0}}} : '0;

  always_comb begin
    w_nx = r_st;
    unique case (r_st)
      IDLE:      if (r_pend && !w_hit && !w_kill) w_nx = MISS_REQ;
      MISS_REQ:  if (mem_req_ready_i) w_nx = MISS_WAIT;
      MISS_WAIT: begin
        if (w_last)
          w_nx = (w_err_any && !w_killed_now) ? ERR : IDLE;
      end
      ERR:       w_nx = IDLE;
      default:   w_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_st <= IDLE;
    else         r_st <= w_nx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req_addr <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (w_accept) r_req_addr <= fet_vaddr_i;
      if (w_kill)                     r_pend <= 1'b0;
      else if (w_accept)              r_pend <= 1'b1;
      else if (w_hit_rsp)             r_pend <= 1'b0;
      else if (r_st == ERR)           r_pend <= 1'b0;
    end
  end

  // Refill bookkeeping: the line may be killed mid-fill but still drains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_line     <= '0;
      r_tag      <= '0;
      r_lv       <= 1'b0;
      r_killed   <= 1'b0;
      r_kbf      <= 1'b0;
      r_err_seen <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_hshk) begin
        r_cnt      <= '0;
        r_err_seen <= 1'b0;
        r_tag      <= r_req_addr[AWTH-1:OFF];
        r_lv       <= 1'b0;
      end
      if (w_refill && w_kill)  r_killed <= 1'b1;
      if (w_refill && flush_i) r_kbf    <= 1'b1;
      if (w_beat) begin
        for (int b = 0; b < BEATS; b++)
          if (r_cnt == CW'(b)) r_line[b*WPB +: WPB] <= mem_rsp_data_i;
        r_cnt <= (r_cnt == CW'(BEATS - 1)) ? '0 : r_cnt + 1'b1;
        if (mem_rsp_err_i) r_err_seen <= 1'b1;
      end
      if (w_last) begin
        r_lv       <= !w_err_any && !w_kbf_now;
        r_killed   <= 1'b0;
        r_kbf      <= 1'b0;
        r_err_seen <= 1'b0;
      end
      if (flush_i) r_lv <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (rst_ni) assert (!(r_st == IDLE && mem_rsp_valid_i));
  end

endmodule

// File: tb/tb_sy_ppl_fetch_lbuf.sv
// Bench for sy_ppl_fetch_lbuf: directed scenarios plus random fetches
// checked against a single-line cache model.
module tb_sy_ppl_fetch_lbuf;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        fet_req_i = 1'b0;
  logic [63:0] fet_vaddr_i = '0;
  logic        fet_kill_i = 1'b0;
  logic        fet_ready_o;
  logic        fet_valid_o;
  logic [31:0] fet_data_o;
  logic        fet_ex_valid_o;
  logic [63:0] fet_ex_tval_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [63:0] mem_req_addr_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [63:0] mem_rsp_data_i = '0;
  logic        mem_rsp_err_i = 1'b0;
  logic        mem_rsp_last_i = 1'b0;

  int total = 0;
  int bad = 0;

  logic [63:0] bd [2];
  bit          be [2];
  int          rdly;
  int          gap_max;
  int          kb;
  bit          kfl;

  bit          m_valid = 1'b0;
  logic [59:0] m_la = '0;
  logic [31:0] m_w [4];

  always #5 clk_i = ~clk_i;

  sy_ppl_fetch_lbuf dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .fet_req_i(fet_req_i), .fet_vaddr_i(fet_vaddr_i),
    .fet_kill_i(fet_kill_i), .fet_ready_o(fet_ready_o),
    .fet_valid_o(fet_valid_o), .fet_data_o(fet_data_o),
    .fet_ex_valid_o(fet_ex_valid_o), .fet_ex_tval_o(fet_ex_tval_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_err_i(mem_rsp_err_i),
    .mem_rsp_last_i(mem_rsp_last_i)
  );

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic nx();
    @(negedge clk_i);
  endtask

  task automatic tk();
    @(posedge clk_i);
    #1;
  endtask

  task automatic serve(input logic [63:0] a);
    logic [63:0] ea;
    ea = {a[63:4], 4'h0};
    repeat (rdly) begin
      nx();
      chk("mreq_v_hold", {63'b0, mem_req_valid_o}, 64'd1);
      chk("mreq_a_hold", mem_req_addr_o, ea);
      tk();
    end
    mem_req_ready_i = 1'b1;
    nx();
    chk("mreq_v", {63'b0, mem_req_valid_o}, 64'd1);
    chk("mreq_a", mem_req_addr_o, ea);
    tk();
    mem_req_ready_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        nx();
        chk("fill_v", {63'b0, fet_valid_o}, 64'd0);
        chk("fill_rdy", {63'b0, fet_ready_o}, 64'd0);
        tk();
      end
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = bd[b];
      mem_rsp_err_i   = be[b];
      mem_rsp_last_i  = (b == 1);
      if (kb == b) begin
        if (kfl) flush_i = 1'b1;
        else     fet_kill_i = 1'b1;
      end
      nx();
      chk("beat_v", {63'b0, fet_valid_o}, 64'd0);
      tk();
      mem_rsp_valid_i = 1'b0;
      mem_rsp_err_i   = 1'b0;
      mem_rsp_last_i  = 1'b0;
      flush_i         = 1'b0;
      fet_kill_i      = 1'b0;
    end
  endtask

  task automatic do_fetch(input logic [63:0] a);
    bit hit;
    bit errl;
    hit = m_valid && (m_la == a[63:4]);
    fet_req_i   = 1'b1;
    fet_vaddr_i = a;
    nx();
    chk("req_rdy", {63'b0, fet_ready_o}, 64'd1);
    tk();
    fet_req_i = 1'b0;
    if (hit) begin
      nx();
      chk("hit_v", {63'b0, fet_valid_o}, 64'd1);
      chk("hit_d", {32'b0, fet_data_o}, {32'b0, m_w[a[3:2]]});
      chk("hit_ex", {63'b0, fet_ex_valid_o}, 64'd0);
      chk("hit_mreq", {63'b0, mem_req_valid_o}, 64'd0);
      tk();
      return;
    end
    nx();
    chk("miss_v", {63'b0, fet_valid_o}, 64'd0);
    chk("miss_rdy", {63'b0, fet_ready_o}, 64'd0);
    tk();
    serve(a);
    errl = be[0] | be[1];
    nx();
    if (kb >= 0) begin
      chk("kill_v", {63'b0, fet_valid_o}, 64'd0);
      chk("kill_rdy", {63'b0, fet_ready_o}, 64'd1);
    end else if (errl) begin
      chk("err_v", {63'b0, fet_valid_o}, 64'd1);
      chk("err_ex", {63'b0, fet_ex_valid_o}, 64'd1);
      chk("err_tval", fet_ex_tval_o, a);
      chk("err_d", {32'b0, fet_data_o}, 64'd0);
    end
    if (errl || (kb >= 0 && kfl)) begin
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b1;
      m_la    = a[63:4];
      m_w[0]  = bd[0][31:0];
      m_w[1]  = bd[0][63:32];
      m_w[2]  = bd[1][31:0];
      m_w[3]  = bd[1][63:32];
    end
    if (kb < 0 && !errl) begin
      chk("fill_rsp_v", {63'b0, fet_valid_o}, 64'd1);
      chk("fill_rsp_d", {32'b0, fet_data_o}, {32'b0, m_w[a[3:2]]});
      chk("fill_rsp_ex", {63'b0, fet_ex_valid_o}, 64'd0);
    end
    tk();
  endtask

  task automatic rnd_data();
    bd[0] = {$urandom, $urandom};
    bd[1] = {$urandom, $urandom};
    be[0] = 1'b0;
    be[1] = 1'b0;
  endtask

  initial begin
    rdly = 0; gap_max = 0; kb = -1; kfl = 1'b0;
    rnd_data();
    nx();
    chk("rst_rdy", {63'b0, fet_ready_o}, 64'd1);
    chk("rst_v", {63'b0, fet_valid_o}, 64'd0);
    chk("rst_mreq", {63'b0, mem_req_valid_o}, 64'd0);
    chk("rst_ex", {63'b0, fet_ex_valid_o}, 64'd0);
    chk("rst_d", {32'b0, fet_data_o}, 64'd0);
    tk();
    rst_ni = 1'b1;
    tk();

    bd[0] = 64'h11112222_33334444;
    bd[1] = 64'h55556666_77778888;
    do_fetch(64'h8000_0004);

    fet_req_i = 1'b1;
    fet_vaddr_i = 64'h8000_000C;
    tk();
    fet_vaddr_i = 64'h8000_0008;
    nx();
    chk("b2b_v0", {63'b0, fet_valid_o}, 64'd1);
    chk("b2b_d0", {32'b0, fet_data_o}, 64'h5555_6666);
    chk("b2b_rdy", {63'b0, fet_ready_o}, 64'd1);
    tk();
    fet_req_i = 1'b0;
    nx();
    chk("b2b_v1", {63'b0, fet_valid_o}, 64'd1);
    chk("b2b_d1", {32'b0, fet_data_o}, 64'h7777_8888);
    chk("b2b_mreq", {63'b0, mem_req_valid_o}, 64'd0);
    tk();

    rnd_data();
    rdly = 5;
    do_fetch(64'h8000_0100);
    rdly = 0;

    bd[0] = 64'h11112222_33334444;
    bd[1] = 64'h55556666_77778888;
    kb = 0;
    do_fetch(64'h8000_0004);
    kb = -1;
    do_fetch(64'h8000_0000);

    rnd_data();
    do_fetch(64'h8000_0200);
    be[0] = 1'b1;
    do_fetch(64'h8000_0004);
    be[0] = 1'b0;
    do_fetch(64'h8000_0004);

    rnd_data();
    kb = 1; kfl = 1'b1;
    do_fetch(64'h8000_0300);
    kb = -1; kfl = 1'b0;
    do_fetch(64'h8000_0300);

    gap_max = 2;
    for (int i = 0; i < 60; i++) begin
      rnd_data();
      be[0] = ($urandom_range(0, 7) == 0);
      be[1] = ($urandom_range(0, 7) == 0);
      rdly  = $urandom_range(0, 3);
      kb    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : -1;
      kfl   = 1'($urandom_range(0, 1));
      do_fetch(64'h8000_1000 + 64'($urandom_range(0, 3) * 16)
               + 64'($urandom_range(0, 7) * 2));
    end
    kb = -1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sy_ppl_fetch_lbuf.md
Name: sy_ppl_fetch_lbuf

Overview:
- L0 fetch line buffer sitting directly upstream of the fronted fetch stage, in the I$ slot.
- Accepts one fetch request per cycle (vaddr, kill) and returns the aligned 32-bit word containing vaddr, with 1-cycle latency on a hit.
- On a miss it refills one line from the memory port over a valid/ready request channel and a beat-wise response channel.
- Reports refill bus errors as fetch exceptions.

Parameters:
AWTH, 64, virtual/physical address width.
LINE_BYTES, 16, line size in bytes; power of two, at least MWTH/8.
MWTH, 64, memory response data width; BEATS = LINE_BYTES*8/MWTH.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
flush_i  in  1  invalidate line; also acts as kill.
fet_req_i  in  1  fetch request.
fet_vaddr_i  in  AWTH  fetch address (2-byte aligned).
fet_kill_i  in  1  discard the outstanding request/response.
fet_ready_o  out  1  request may be accepted.
fet_valid_o  out  1  response valid.
fet_data_o  out  32  aligned word at {vaddr[AWTH-1:2],2'b0}.
fet_ex_valid_o  out  1  fetch access fault.
fet_ex_tval_o  out  AWTH  faulting vaddr.
mem_req_valid_o  out  1  refill request.
mem_req_ready_i  in  1  refill request accepted.
mem_req_addr_o  out  AWTH  line-aligned refill address.
mem_rsp_valid_i  in  1  refill beat valid.
mem_rsp_data_i  in  MWTH  refill beat, increasing address order.
mem_rsp_err_i  in  1  beat carries a bus error.
mem_rsp_last_i  in  1  final beat of the line.

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE; line_valid=0; pending=0; killed=0; beat counter 0.
  - All outputs 0 except fet_ready_o=1.
- Storage: one line (data, tag = addr[AWTH-1:log2(LINE_BYTES)], line_valid). Word select is addr[log2(LINE_BYTES)-1:2]; words are little-endian within a beat.
- Accept: fet_req_i && fet_ready_o && !fet_kill_i && !flush_i. Latches vaddr into req_addr and sets pending=1.
- States: IDLE, MISS_REQ, MISS_WAIT, ERR.
- IDLE, pending=1, line_valid && tag hit:
  - fet_valid_o=1 with the selected word; pending cleared.
  - fet_ready_o=1, so throughput is one hit per cycle.
- IDLE, pending=1, miss:
  - fet_ready_o=0; go to MISS_REQ.
- IDLE, pending=0: fet_ready_o=1.
- MISS_REQ:
  - mem_req_valid_o=1, addr = line-aligned req_addr, held stable until mem_req_ready_i.
  - On handshake go to MISS_WAIT with counter=0.
  - mem_req_valid_o is never withdrawn, even on kill.
- MISS_WAIT:
  - Each mem_rsp_valid_i writes beat[counter] into the line buffer; counter++ and wraps at BEATS.
  - Any err beat sets err_seen.
  - While filling, line_valid=0 and the tag is updated to the new line.
  - On a valid last beat:
    - err_seen, or err on this beat: line_valid stays 0. Go to ERR if !killed, else IDLE with pending=0.
    - Otherwise: line_valid=1 unless killed_by_flush. Go to IDLE; pending still set, so the response issues from the hit path next cycle (miss latency = last beat + 1).
    - If killed, pending is cleared, so there is no response, but the line is still installed.
- ERR (one cycle): fet_valid_o=1, fet_ex_valid_o=1, fet_ex_tval_o=req_addr, fet_data_o=0; pending cleared; go to IDLE.
- fet_ready_o=0 in MISS_REQ, MISS_WAIT and ERR.
- Kill (fet_kill_i or flush_i), in any state:
  - pending cleared; fet_valid_o forced 0 that cycle.
  - If a refill is in progress, killed=1 and the refill runs to completion (beats drained).
  - A request presented in the same cycle as a kill is not accepted.
- flush_i: clears line_valid immediately; during a refill it also sets killed_by_flush so the line is not installed.
- fet_ex_valid_o is only ever high together with fet_valid_o.
- Memory response beats arriving in IDLE are ignored (protocol violation, assert in sim).

Test Plan:
- Reset -> fet_ready_o=1, fet_valid_o=0, mem_req_valid_o=0; req 0x8000_0004 -> mem_req_valid_o=1, mem_req_addr_o=0x8000_0000 on cycle+2.
- Cold miss: beats 0x11112222_33334444, then 0x55556666_77778888 with last -> fet_valid_o=1, data 0x11112222, exactly 1 cycle after last beat.
- Hits after fill:
  - req 0x8000_000C, then 0x8000_0008 on consecutive cycles -> data 0x55556666 then 0x77778888 on consecutive cycles.
  - mem_req_valid_o stays 0.
- Hold mem_req_ready_i=0 for 5 cycles -> mem_req_valid_o/addr stable.
- Kill during MISS_WAIT:
  - No fet_valid_o for that request; fill completes.
  - Next req 0x8000_0000 hits with data 0x33334444 in 1 cycle.
- Fill error:
  - Beat 0 with err, last beat clean -> fet_valid_o=1, fet_ex_valid_o=1, fet_ex_tval_o=0x8000_0004.
  - Re-request of 0x8000_0004 misses again.
- flush_i during MISS_WAIT -> no response, line not installed; subsequent req to same line issues mem request.
